// File: rtl/instruction_queue.sv
// instruction_queue: in-order instruction FIFO issuing the head entry to one of three execution units
module instruction_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  queue_we,
  input  logic [1:0]            queue_instr_type,
  input  logic [0:8]            queue_arith_instr,
  input  logic [0:2]            queue_ram_instr,
  input  logic [0:6]            queue_ld_st_instr,
  input  logic [17:0]           cache_addr,
  input  logic [17:0]           d_cache_addr,
  input  logic [17:0]           main_mem_addr,
  input  logic [17:0]           d_main_mem_addr,
  output logic                  queue_full,
  output logic                  queue_empty,
  output logic [DEPTH_LOG2:0]   queue_count,
  output logic                  arith_valid,
  input  logic                  arith_ready,
  output logic [0:8]            arith_instr,
  output logic                  ram_valid,
  input  logic                  ram_ready,
  output logic [0:2]            ram_instr,
  output logic                  ldst_valid,
  input  logic                  ldst_ready,
  output logic [0:6]            ldst_instr,
  output logic [17:0]           out_cache_addr,
  output logic [17:0]           out_d_cache_addr,
  output logic [17:0]           out_main_mem_addr,
  output logic [17:0]           out_d_main_mem_addr,
  output logic                  overflow,
  output logic                  illegal_instr
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd0;
  localparam logic [1:0] INSTR_TYPE_RAM = 2'd1;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd2;
  typedef struct packed {
    logic [1:0]  t;
    logic [8:0]  arith;
    logic [2:0]  ram;
    logic [6:0]  ldst;
    logic [17:0] ca;
    logic [17:0] dca;
    logic [17:0] ma;
    logic [17:0] dma;
  } entry_t;
  entry_t                storage [DEPTH];
  entry_t                head;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push;
  logic                  pop;
  logic                  illegal_head;
  // head view, issue selection and handshake decode; everything reads as zero when empty
  always_comb begin
    queue_count = count;
    queue_empty = count == '0;
    queue_full = count == FULL_COUNT;
    head = queue_empty ? '0 : storage[rd_ptr];
    arith_valid = !queue_empty && head.t == INSTR_TYPE_ARITHMETIC;
    ram_valid = !queue_empty && head.t == INSTR_TYPE_RAM;
    ldst_valid = !queue_empty && head.t == INSTR_TYPE_LOAD_STORE;
    illegal_head = !queue_empty && !arith_valid && !ram_valid && !ldst_valid;
    arith_instr = head.arith;
    ram_instr = head.ram;
    ldst_instr = head.ldst;
    out_cache_addr = head.ca;
    out_d_cache_addr = head.dca;
    out_main_mem_addr = head.ma;
    out_d_main_mem_addr = head.dma;
    push = queue_we && !queue_full;
    pop = (arith_valid && arith_ready) || (ram_valid && ram_ready) || (ldst_valid && ldst_ready) || illegal_head;
  end
  // entry storage: every field is kept whatever the type
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= '{queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr, cache_addr, d_cache_addr, main_mem_addr, d_main_mem_addr};
  end
  // pointers, occupancy and error flags; illegal heads are dropped with a one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      overflow <= overflow || (queue_we && queue_full);
      illegal_instr <= illegal_head;
    end
  end
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed and random stimulus checked against a queue-based reference model
module tb_instruction_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        queue_we;
  logic [1:0]  queue_instr_type;
  logic [0:8]  queue_arith_instr;
  logic [0:2]  queue_ram_instr;
  logic [0:6]  queue_ld_st_instr;
  logic [17:0] cache_addr, d_cache_addr, main_mem_addr, d_main_mem_addr;
  logic        queue_full, queue_empty;
  logic [4:0]  queue_count;
  logic        arith_valid, arith_ready, ram_valid, ram_ready, ldst_valid, ldst_ready;
  logic [0:8]  arith_instr;
  logic [0:2]  ram_instr;
  logic [0:6]  ldst_instr;
  logic [17:0] out_cache_addr, out_d_cache_addr, out_main_mem_addr, out_d_main_mem_addr;
  logic        overflow, illegal_instr;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [1:0]  t;
    logic [8:0]  a;
    logic [2:0]  r;
    logic [6:0]  l;
    logic [17:0] ca, dca, ma, dma;
  } ent_t;
  ent_t q[$];
  bit m_ovf = 0;
  bit m_ill = 0;
  instruction_queue dut (
    .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
    .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr), .queue_ld_st_instr(queue_ld_st_instr),
    .cache_addr(cache_addr), .d_cache_addr(d_cache_addr), .main_mem_addr(main_mem_addr), .d_main_mem_addr(d_main_mem_addr),
    .queue_full(queue_full), .queue_empty(queue_empty), .queue_count(queue_count),
    .arith_valid(arith_valid), .arith_ready(arith_ready), .arith_instr(arith_instr),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_instr(ram_instr),
    .ldst_valid(ldst_valid), .ldst_ready(ldst_ready), .ldst_instr(ldst_instr),
    .out_cache_addr(out_cache_addr), .out_d_cache_addr(out_d_cache_addr),
    .out_main_mem_addr(out_main_mem_addr), .out_d_main_mem_addr(out_d_main_mem_addr),
    .overflow(overflow), .illegal_instr(illegal_instr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rnd_fields();
    queue_arith_instr = 9'($urandom);
    queue_ram_instr = 3'($urandom);
    queue_ld_st_instr = 7'($urandom);
    cache_addr = 18'($urandom);
    d_cache_addr = 18'($urandom);
    main_mem_addr = 18'($urandom);
    d_main_mem_addr = 18'($urandom);
  endtask
  task automatic push_ent(input logic [1:0] t);
    queue_we = 1'b1;
    queue_instr_type = t;
    rnd_fields();
  endtask
  task automatic readies(input bit a, input bit r, input bit l);
    arith_ready = a;
    ram_ready = r;
    ldst_ready = l;
  endtask
  // check the DUT against the model mid-cycle, then advance the model across the edge
  task automatic tick();
    ent_t h;
    bit ne, pop, push;
    #2;
    ne = q.size() != 0;
    h = ne ? q[0] : '0;
    chk("count", 72'(queue_count), 72'(q.size()));
    chk("empty", 72'(queue_empty), 72'(!ne));
    chk("full", 72'(queue_full), 72'(q.size() == 16));
    chk("valids", 72'({arith_valid, ram_valid, ldst_valid}), 72'({ne && h.t == 2'd0, ne && h.t == 2'd1, ne && h.t == 2'd2}));
    chk("arith_instr", 72'(arith_instr), 72'(h.a));
    chk("ram_instr", 72'(ram_instr), 72'(h.r));
    chk("ldst_instr", 72'(ldst_instr), 72'(h.l));
    chk("addrs", {out_cache_addr, out_d_cache_addr, out_main_mem_addr, out_d_main_mem_addr}, {h.ca, h.dca, h.ma, h.dma});
    chk("overflow", 72'(overflow), 72'(m_ovf));
    chk("illegal", 72'(illegal_instr), 72'(m_ill));
    pop = ne && (h.t == 2'd3 || (h.t == 2'd0 && arith_ready) || (h.t == 2'd1 && ram_ready) || (h.t == 2'd2 && ldst_ready));
    push = queue_we && q.size() < 16;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_ill = 0;
    end else begin
      m_ovf = m_ovf || (queue_we && q.size() == 16);
      m_ill = ne && h.t == 2'd3;
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr, cache_addr, d_cache_addr, main_mem_addr, d_main_mem_addr});
    end
  endtask
  initial begin
    reset = 1'b1;
    queue_we = 1'b0;
    queue_instr_type = 2'd0;
    rnd_fields();
    readies(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    tick();
    // single RAM transfer
    readies(0, 1, 0);
    push_ent(2'd1);
    queue_ram_instr = {1'b0, 2'd2};
    cache_addr = 18'd0;
    d_cache_addr = 18'd1;
    main_mem_addr = 18'd16;
    d_main_mem_addr = 18'd4;
    tick();
    queue_we = 1'b0;
    repeat (2) tick();
    // back-to-back mixed pushes, everything ready
    readies(1, 1, 1);
    push_ent(2'd1); tick();
    push_ent(2'd2); tick();
    push_ent(2'd0); queue_arith_instr = 9'b000110000; tick();
    push_ent(2'd2); tick();
    push_ent(2'd1); tick();
    queue_we = 1'b0;
    repeat (3) tick();
    // fill to full, overflow on the 17th, drain in order
    readies(0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      push_ent(2'($urandom_range(0, 2)));
      tick();
    end
    queue_we = 1'b0;
    tick();
    readies(1, 1, 1);
    repeat (17) tick();
    // stalled load/store head blocks a younger arithmetic entry
    readies(0, 0, 0);
    push_ent(2'd2); tick();
    push_ent(2'd0); tick();
    queue_we = 1'b0;
    readies(1, 1, 0);
    repeat (5) tick();
    readies(1, 1, 1);
    repeat (3) tick();
    // illegal entry between two arithmetic entries
    readies(1, 0, 0);
    push_ent(2'd0); tick();
    push_ent(2'd3); tick();
    push_ent(2'd0); tick();
    queue_we = 1'b0;
    repeat (4) tick();
    // reset with a partly filled queue
    readies(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      push_ent(2'($urandom_range(0, 2)));
      tick();
    end
    queue_we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    // wrap pointers with interleaved pops
    for (int i = 0; i < 17; i++) begin
      push_ent(2'($urandom_range(0, 2)));
      readies(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    // random traffic: low-ready phase to hit full, then high-ready phase
    for (int i = 0; i < 400; i++) begin
      queue_we = 1'($urandom_range(0, 1));
      queue_instr_type = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      rnd_fields();
      if (i < 200) readies($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      else readies($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
